// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, synchronous active-low clear; q updates one edge after inc.
// No backpressure: inc is accepted every cycle and ignored once q is all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges load-use, branch/jump, mult/div and data-memory events into pipeline-register
// enables; controls are combinational (0 latency), state and statistics are registered.
module pipeline_stall_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int TO_W        = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    if (!rst_n) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
      state_d       = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            state_d      = MEM_WAIT;
          end else if (md_start && !md_done) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            state_d       = MD_WAIT;
          end else if (load_use_hazard) begin
            // A branch seen alongside the hazard is re-presented by ID next cycle.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (branch_taken || jump) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!md_done) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Timeout counts consecutive frozen MEM_WAIT cycles; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      mem_timeout <= 1'b0;
    end else if ((state_q == MEM_WAIT) && !mem_ready) begin
      if (to_cnt_q != '1) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!PCWrite),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_Flush),
    .q     (flush_count)
  );

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage MIPS pipeline's freeze, stall, bubble and flush controls.
- Merges four event sources into one consistent set of pipeline-register enables:
  - load-use hazard flag from hazard_unit
  - taken branch/jump resolved in ID
  - multi-cycle mult/div busy handshake
  - data-memory wait handshake
- Also keeps saturating stall and flush statistics, plus a sticky memory-timeout flag.

Parameters:
- CNT_W, 16: width of the stall_cycles and flush_count counters.
- MEM_TIMEOUT, 64: number of MEM_WAIT cycles after which mem_timeout is set.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous, active-low reset.
- load_use_hazard, input, 1: Mux_Select_Stall request from hazard_unit.
- branch_taken, input, 1: branch in ID resolved taken.
- jump, input, 1: jump in ID.
- md_start, input, 1: mult/div instruction present in EX this cycle.
- md_done, input, 1: mult/div unit result valid.
- mem_req, input, 1: EX_MEM MemRead|MemWrite.
- mem_ready, input, 1: data memory completes the access this cycle.
- PCWrite, output, 1: PC load enable.
- IF_ID_Write, output, 1: IF/ID register enable.
- IF_ID_Flush, output, 1: zero the IF/ID register at the next edge.
- ID_EX_Write, output, 1: ID/EX register enable.
- ID_EX_Bubble, output, 1: force ID/EX control signals to 0.
- EX_MEM_Write, output, 1: EX/MEM register enable.
- EX_MEM_Bubble, output, 1: force EX/MEM control signals to 0.
- stall_cycles, output, CNT_W: count of cycles with PCWrite=0.
- flush_count, output, CNT_W: count of IF_ID_Flush pulses.
- mem_timeout, output, 1: sticky memory-timeout error.

Behaviour:
- Reset:
  - Reset is synchronous, active-low.
  - rst_n=0 at a clock edge sets: state=RUN, counters=0, timeout counter=0, mem_timeout=0.
  - While rst_n=0, outputs are forced to: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1, EX_MEM_Bubble=1. Counters do not count.
- States: RUN, MD_WAIT, MEM_WAIT (2-bit encoding).
- Control outputs are combinational from state and inputs, so a stall takes effect in the same cycle the request is seen (0 latency). Counters and state are registered.
- Default (RUN, no events): all Write signals=1; Flush=0; both Bubble signals=0.
- Priority in RUN, evaluated each cycle, highest first:
  1. mem_req & !mem_ready → full freeze:
     - all four Write signals=0; both Bubble signals=0; Flush=0.
     - next state=MEM_WAIT.
  2. md_start & !md_done → EX holds the mult/div op:
     - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0.
     - EX_MEM_Bubble=1; EX_MEM_Write=1.
     - next state=MD_WAIT.
     - md_start & md_done in the same cycle → no stall; stay in RUN.
  3. load_use_hazard → single-cycle stall:
     - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
     - stay in RUN.
     - branch_taken/jump in the same cycle is ignored; ID re-evaluates it next cycle.
  4. branch_taken|jump → IF_ID_Flush=1 for one cycle; PC still writes (target).
- MEM_WAIT:
  - Full freeze while mem_ready=0.
  - In the cycle mem_ready=1, the freeze is released combinationally and next state=RUN.
  - The timeout counter increments each MEM_WAIT cycle; when it reaches MEM_TIMEOUT, mem_timeout=1 (sticky). The freeze still continues.
  - The timeout counter clears on leaving MEM_WAIT.
  - All other inputs are ignored.
- MD_WAIT:
  - Same outputs as RUN priority 2 while md_done=0.
  - In the md_done=1 cycle, all Write signals=1 and both Bubble signals=0; next state=RUN.
  - A mem_req & !mem_ready arising in MD_WAIT is ignored: EX_MEM holds a bubble.
  - load_use_hazard, branch_taken and jump are ignored; they are re-presented because ID is frozen.
- stall_cycles: +1 on each non-reset cycle with PCWrite=0; saturates at all-ones.
- flush_count: +1 per IF_ID_Flush cycle; saturates at all-ones.
- Reset mid-MEM_WAIT or mid-MD_WAIT: the next edge returns the block to RUN; no partial state survives.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings: RUN=2'd0, MD_WAIT=2'd1, MEM_WAIT=2'd2
  - default CNT_W and MEM_TIMEOUT
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output q), instantiated twice, for stall_cycles and flush_count.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → PCWrite=0, ID_EX_Bubble=1, stall_cycles=0. After release with no events → all Write signals=1, stall_cycles remains 0.
- Load-use: load_use_hazard=1 for 1 cycle → PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly that cycle; stall_cycles=1.
- Load-use plus branch: load_use_hazard=1 and branch_taken=1 together → Flush=0, stall asserted. Next cycle branch_taken=1 alone → Flush=1; flush_count=1.
- Mult/div: md_start=1, then md_done=1 four cycles later → MD_WAIT for 4 cycles with EX_MEM_Bubble=1; return to RUN; stall_cycles=5.
- Memory wait: mem_req=1 with mem_ready=0 for 70 cycles → full freeze; mem_timeout=1 from the cycle the counter reaches 64. mem_ready=1 → RUN; mem_timeout stays 1 until reset.
- Reset mid-MEM_WAIT: drop rst_n after 10 wait cycles → state=RUN, counters=0, mem_timeout=0.
